// File: rtl/ahb_mst_pkg.sv
// -----------------------------------------------------------------------------
// ahb_mst_pkg
//   Shared types and defaults for the AHB-Lite command-stream master.
//   - state_e           : pipeline state (which bus phases are in flight)
//   - *_DEFAULT         : default widths and stall limit for ahb_lite_master
//   - has_addr_phase()  : state carries an address phase on the bus
//   - has_data_phase()  : state carries a data phase on the bus
// -----------------------------------------------------------------------------
package ahb_mst_pkg;

    localparam int ADDR_W_DEFAULT         = 7;
    localparam int DATA_W_DEFAULT         = 32;
    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        DATA      = 2'd2,
        ADDR_DATA = 2'd3
    } state_e;

    function automatic logic has_addr_phase(input state_e s);
        return (s == ADDR) || (s == ADDR_DATA);
    endfunction

    function automatic logic has_data_phase(input state_e s);
        return (s == DATA) || (s == ADDR_DATA);
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// -----------------------------------------------------------------------------
// ahb_lite_master
//   Turns a valid/ready command stream into pipelined AHB-Lite transfers
//   toward an AHB-to-APB bridge. The address phase of transfer N+1 overlaps
//   the data phase of transfer N; each completed data phase produces a
//   one-cycle response strobe on the following cycle.
//
//   Optional feature (compile-time macro AHB_MST_TIMEOUT_EN):
//     a stall counter aborts a data phase held off by HREADYOUT=0 for
//     TIMEOUT_CYCLES cycles and returns rsp_err=1. Without the macro the
//     master waits indefinitely and rsp_err is always 0.
//
// Ports
//   HCLK, RESET             clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (accepted when both are high)
//   cmd_write/addr/wdata    command payload
//   rsp_valid               one-cycle completion pulse (no backpressure)
//   rsp_rdata/rsp_err       read data (0 for writes) / timeout abort flag
//   HSEL/HADDR/HWRITE       registered address-phase outputs
//   HWDATA                  write data, driven during the write data phase
//   HREADY                  copy of HREADYOUT (single-slave interconnect)
//   HREADYOUT/HRDATA        bridge ready and read data
// -----------------------------------------------------------------------------
module ahb_lite_master
    import ahb_mst_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              HCLK,
    input  logic              RESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              HSEL,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HREADY,
    input  logic              HREADYOUT,
    input  logic [DATA_W-1:0] HRDATA
);

    state_e              state_q, state_d;
    logic                hsel_q, hsel_d;
    logic [ADDR_W-1:0]   haddr_q, haddr_d;
    logic                hwrite_q, hwrite_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;     // write data of the pending address phase
    logic [DATA_W-1:0]   hwdata_q, hwdata_d;
    logic                dwrite_q, dwrite_d;   // direction of the transfer in data phase
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic accept;
    logic data_done;
    logic timeout_hit;

    // A new address phase may start from IDLE at any time, otherwise only on
    // an edge where the current phases advance.
    assign cmd_ready = !RESET && ((state_q == IDLE) || HREADYOUT);
    assign accept    = cmd_valid && cmd_ready;
    assign data_done = HREADYOUT && has_data_phase(state_q);

`ifdef AHB_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stalled;

    assign stalled     = !HREADYOUT && has_data_phase(state_q);
    // Fires on the TIMEOUT_CYCLES-th consecutive stalled edge.
    assign timeout_hit = stalled && (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign stall_cnt_d = (stalled && !timeout_hit) ? stall_cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge HCLK) begin
        if (RESET) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: every variable gets its hold value first so no path through the
    // block leaves it unassigned; a missing default here infers a latch.
    always_comb begin
        state_d     = state_q;
        hsel_d      = hsel_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        wdata_d     = wdata_q;
        hwdata_d    = hwdata_q;
        dwrite_d    = dwrite_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = 1'b0;

        // Response for the data phase finishing (or being aborted) this edge.
        if (data_done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = dwrite_q ? '0 : HRDATA;
        end else if (timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
        end

        // Address phase moves into the data phase.
        if (HREADYOUT && has_addr_phase(state_q)) begin
            dwrite_d = hwrite_q;
            if (hwrite_q) begin
                hwdata_d = wdata_q;
            end
            hsel_d = 1'b0;
        end

        // A newly accepted command overrides the HSEL drop above.
        if (accept) begin
            hsel_d   = 1'b1;
            haddr_d  = cmd_addr;
            hwrite_d = cmd_write;
            wdata_d  = cmd_wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ADDR;
            end
            ADDR: begin
                if (HREADYOUT) state_d = accept ? ADDR_DATA : DATA;
            end
            DATA: begin
                if (HREADYOUT)        state_d = accept ? ADDR : IDLE;
                else if (timeout_hit) state_d = IDLE;
            end
            ADDR_DATA: begin
                // On abort the overlapped address phase stays on the bus.
                if (HREADYOUT)        state_d = accept ? ADDR_DATA : DATA;
                else if (timeout_hit) state_d = ADDR;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge HCLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            wdata_q     <= '0;
            hwdata_q    <= '0;
            dwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            wdata_q     <= wdata_d;
            hwdata_q    <= hwdata_d;
            dwrite_q    <= dwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HREADY    = HREADYOUT;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// -----------------------------------------------------------------------------
// tb_ahb_lite_master
//   Directed bench for ahb_lite_master. Expected responses are queued when a
//   command is issued and compared as rsp_valid pulses appear. Inputs are
//   driven and outputs sampled on the falling edge of HCLK.
//   The timeout step is compiled only with AHB_MST_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_ahb_lite_master;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          HCLK;
    logic          RESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [DW-1:0] HRDATA;

    ahb_lite_master #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK     (HCLK),
        .RESET    (RESET),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HREADYOUT(HREADYOUT),
        .HRDATA   (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   rsp_seen = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each response pulse pops the oldest expected response.
    always @(negedge HCLK) begin : monitor
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            rsp_seen++;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL rsp_unexpected observed=rsp_valid expected=no_response");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
        end
    end

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit push, input logic err, input logic [DW-1:0] rd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        #1;
        check("cmd_ready_on_issue", 64'(cmd_ready), 64'd1);
        if (push) exp_q.push_back({err, rd});
    endtask

    task automatic check_bus(input string tag, input logic sel, input logic [AW-1:0] a,
                             input logic wr);
        check({tag, "_hsel"}, 64'(HSEL), 64'(sel));
        check({tag, "_haddr"}, 64'(HADDR), 64'(a));
        check({tag, "_hwrite"}, 64'(HWRITE), 64'(wr));
    endtask

    task automatic check_reset_vals(input string tag);
        check_bus(tag, 1'b0, '0, 1'b0);
        check({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int r0;

        RESET     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        HREADYOUT = 1'b1;
        HRDATA    = '0;
        step();
        step();
        check_reset_vals("rst");
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        RESET = 1'b0;
        step();
        check_reset_vals("post_rst");
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // Single write, zero wait states.
        r0 = rsp_seen;
        issue(1'b1, 7'h25, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        step();
        cmd_valid = 1'b0;
        check_bus("t1_addr", 1'b1, 7'h25, 1'b1);
        step();
        check("t1_hsel_drop", 64'(HSEL), 64'd0);
        check("t1_hwdata", 64'(HWDATA), 64'hDEADBEEF);
        check("t1_rsp_early", 64'(rsp_valid), 64'd0);
        step();
        check("t1_rsp", 64'(rsp_valid), 64'd1);
        step();
        check("t1_rsp_once", 64'(rsp_valid), 64'd0);
        drain("t1");
        check("t1_rsp_count", 64'(rsp_seen - r0), 64'd1);

        // Read with two wait states.
        r0 = rsp_seen;
        issue(1'b0, 7'h43, '0, 1'b1, 1'b0, 32'h12345678);
        step();
        cmd_valid = 1'b0;
        check_bus("t2_addr", 1'b1, 7'h43, 1'b0);
        step();
        HREADYOUT = 1'b0;
        HRDATA    = 32'hAAAA5555;
        #1;
        check("t2_cmd_ready_stall", 64'(cmd_ready), 64'd0);
        check("t2_hready_copy", 64'(HREADY), 64'd0);
        check("t2_hsel_drop", 64'(HSEL), 64'd0);
        step();
        check("t2_wait1", 64'(rsp_valid), 64'd0);
        step();
        check("t2_wait2", 64'(rsp_valid), 64'd0);
        HREADYOUT = 1'b1;
        HRDATA    = 32'h12345678;
        step();
        check("t2_rsp", 64'(rsp_valid), 64'd1);
        HRDATA = '0;
        step();
        check("t2_rsp_once", 64'(rsp_valid), 64'd0);
        drain("t2");
        check("t2_rsp_count", 64'(rsp_seen - r0), 64'd1);

        // Back-to-back write / read / write.
        r0     = rsp_seen;
        HRDATA = 32'hCAFEF00D;
        issue(1'b1, 7'h11, 32'h11111111, 1'b1, 1'b0, '0);
        step();
        check_bus("t3_a1", 1'b1, 7'h11, 1'b1);
        issue(1'b0, 7'h22, '0, 1'b1, 1'b0, 32'hCAFEF00D);
        step();
        check_bus("t3_a2", 1'b1, 7'h22, 1'b0);
        check("t3_d1_hwdata", 64'(HWDATA), 64'h11111111);
        issue(1'b1, 7'h33, 32'h33333333, 1'b1, 1'b0, '0);
        step();
        cmd_valid = 1'b0;
        check_bus("t3_a3", 1'b1, 7'h33, 1'b1);
        check("t3_d2_hwdata_hold", 64'(HWDATA), 64'h11111111);
        check("t3_rsp1", 64'(rsp_valid), 64'd1);
        step();
        check("t3_hsel_drop", 64'(HSEL), 64'd0);
        check("t3_d3_hwdata", 64'(HWDATA), 64'h33333333);
        check("t3_rsp2", 64'(rsp_valid), 64'd1);
        step();
        check("t3_rsp3", 64'(rsp_valid), 64'd1);
        step();
        check("t3_rsp_end", 64'(rsp_valid), 64'd0);
        drain("t3");
        check("t3_rsp_count", 64'(rsp_seen - r0), 64'd3);

        // Stall while an address phase overlaps a write data phase.
        r0     = rsp_seen;
        HRDATA = '0;
        issue(1'b1, 7'h05, 32'hA5A5A5A5, 1'b1, 1'b0, '0);
        step();
        issue(1'b0, 7'h46, '0, 1'b1, 1'b0, 32'h0BADF00D);
        step();
        cmd_write = 1'b0;
        cmd_addr  = 7'h6A;
        HREADYOUT = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t4_cmd_ready_stall", 64'(cmd_ready), 64'd0);
            check_bus("t4_hold", 1'b1, 7'h46, 1'b0);
            check("t4_hwdata_hold", 64'(HWDATA), 64'hA5A5A5A5);
            check("t4_no_rsp", 64'(rsp_valid), 64'd0);
            if (i < 3) step();
        end
        HREADYOUT = 1'b1;
        #1;
        check("t4_cmd_ready_resume", 64'(cmd_ready), 64'd1);
        exp_q.push_back({1'b0, 32'h77777777});
        step();
        cmd_valid = 1'b0;
        HRDATA    = 32'h0BADF00D;
        check_bus("t4_a3", 1'b1, 7'h6A, 1'b0);
        check("t4_rsp1", 64'(rsp_valid), 64'd1);
        step();
        HRDATA = 32'h77777777;
        check("t4_hsel_drop", 64'(HSEL), 64'd0);
        step();
        check("t4_rsp3", 64'(rsp_valid), 64'd1);
        drain("t4");
        check("t4_rsp_count", 64'(rsp_seen - r0), 64'd3);
        step();

        // Reset during a waited data phase: transfer dropped, no response.
        r0     = rsp_seen;
        HRDATA = '0;
        issue(1'b1, 7'h7F, 32'hFFFF0000, 1'b0, 1'b0, '0);
        step();
        cmd_valid = 1'b0;
        step();
        HREADYOUT = 1'b0;
        check("t5_hwdata", 64'(HWDATA), 64'hFFFF0000);
        step();
        check("t5_wait1", 64'(rsp_valid), 64'd0);
        step();
        check("t5_wait2", 64'(rsp_valid), 64'd0);
`ifndef AHB_MST_TIMEOUT_EN
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_wait_long", 64'(rsp_valid), 64'd0);
        end
`endif
        RESET = 1'b1;
        step();
        check_reset_vals("t5_rst");
        check("t5_cmd_ready_rst", 64'(cmd_ready), 64'd0);
        RESET     = 1'b0;
        HREADYOUT = 1'b1;
        step();
        check_reset_vals("t5_after");
        check("t5_cmd_ready_idle", 64'(cmd_ready), 64'd1);
        step();
        check("t5_no_rsp", 64'(rsp_seen - r0), 64'd0);

`ifdef AHB_MST_TIMEOUT_EN
        // Data phase stuck for TIMEOUT_CYCLES: abort with error, re-issue overlap.
        r0 = rsp_seen;
        issue(1'b1, 7'h30, 32'h12121212, 1'b1, 1'b1, '0);
        step();
        issue(1'b0, 7'h50, '0, 1'b1, 1'b0, 32'h0000BEEF);
        step();
        cmd_valid = 1'b0;
        HREADYOUT = 1'b0;
        HRDATA    = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            check("t6_no_rsp", 64'(rsp_valid), 64'd0);
            check_bus("t6_hold", 1'b1, 7'h50, 1'b0);
            step();
        end
        check("t6_abort_rsp", 64'(rsp_valid), 64'd1);
        check("t6_abort_err", 64'(rsp_err), 64'd1);
        check_bus("t6_reissue", 1'b1, 7'h50, 1'b0);
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0000BEEF;
        step();
        check("t6_hsel_drop", 64'(HSEL), 64'd0);
        step();
        check("t6_rsp2", 64'(rsp_valid), 64'd1);
        check("t6_rsp2_err", 64'(rsp_err), 64'd0);
        drain("t6");
        check("t6_rsp_count", 64'(rsp_seen - r0), 64'd2);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
